// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-ported data memory: round-robin or fixed-priority grant.
// Latency: req sampled in IDLE -> memory access next cycle -> ack and read data the cycle after.
module dmem_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_read_address,
  output logic [AW-1:0] mem_write_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  output logic          mem_read_en,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_grant;

  // A request still high in the cycle of its own ack is stale and must not re-grant.
  assign w_elig0 = m0_req & ~r_m0_ack;
  assign w_elig1 = m1_req & ~r_m1_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_next = (FIXED_PRIO || r_last_grant) ? S_GRANT0 : S_GRANT1;
        end else if (w_elig0) begin
          w_next = S_GRANT0;
        end else if (w_elig1) begin
          w_next = S_GRANT1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Enables are gated by reset_n so a reset landing in a grant cycle suppresses the access.
  always_comb begin
    w_grant      = (r_state == S_GRANT0) || (r_state == S_GRANT1);
    mem_write_en = reset_n & w_grant & r_cmd_we;
    mem_read_en  = reset_n & w_grant & ~r_cmd_we;
  end

  assign mem_read_address  = r_cmd_addr;
  assign mem_write_address = r_cmd_addr;
  assign mem_write_data    = r_cmd_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
        r_last_grant <= (w_next == S_GRANT1);
        r_cmd_we     <= (w_next == S_GRANT1) ? m1_we    : m0_we;
        r_cmd_addr   <= (w_next == S_GRANT1) ? m1_addr  : m0_addr;
        r_cmd_wdata  <= (w_next == S_GRANT1) ? m1_wdata : m0_wdata;
      end
      if (r_state == S_GRANT0) begin
        r_m0_ack <= 1'b1;
        if (!r_cmd_we) r_m0_rdata <= mem_read_data;
      end
      if (r_state == S_GRANT1) begin
        r_m1_ack <= 1'b1;
        if (!r_cmd_we) r_m1_rdata <= mem_read_data;
      end
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported data memory (256 × 16-bit words, byte-addressed, 2 bytes per word) between the core load/store path (master 0) and a secondary requester such as a loader/DMA or debug port (master 1). It accepts one access per granted request, drives the memory's read/write address, data and enable inputs for exactly one cycle, and returns a registered read word plus a one-cycle acknowledge. Arbitration is round-robin by default, with a fixed-priority option.

## Interface
- AW, 9, byte-address width; equals the memory's $clog2(depth*BPW).
- DW, 16, data width; equals the memory's width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a tie.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- m0_req / m1_req  in  1  request; held with command stable until the matching ack.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  AW  byte address; passed unmodified to the memory.
- m0_wdata / m1_wdata  in  DW  write data.
- m0_ack / m1_ack  out  1  one-cycle pulse: the access has completed.
- m0_rdata / m1_rdata  out  DW  read data; valid while the matching ack is high, held until the next read completes for that master.
- mem_read_address / mem_write_address  out  AW  both driven from the latched address.
- mem_write_data  out  DW  latched write data.
- mem_write_en / mem_read_en  out  1  memory enables.
- mem_read_data  in  DW  combinational read data from the memory.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- Eligibility in IDLE:
  - master x is eligible iff mx_req & ~mx_ack.
  - The ack mask blocks the stale request still visible in the cycle of its own ack.
- IDLE with neither master eligible: stay in IDLE.
- IDLE with exactly one master eligible: go to GRANTx.
- IDLE with both eligible:
  - FIXED_PRIO=1: GRANT0.
  - FIXED_PRIO=0: grant the master not granted last; the last_grant register updates on every grant.
- IDLE → GRANTx edge: latch mx_we, mx_addr, mx_wdata into cmd_we, cmd_addr, cmd_wdata.
- During GRANTx (combinational outputs):
  - mem_write_en = reset_n & cmd_we
  - mem_read_en = reset_n & ~cmd_we
  - both memory addresses = cmd_addr
  - mem_write_data = cmd_wdata
- Outside GRANTx: both enables 0; address and data outputs hold their last values.
- GRANTx → IDLE edge, always:
  - mx_ack <= 1; the other ack <= 0.
  - On a read, mx_rdata <= mem_read_data.
  - On a write, mx_rdata is unchanged.
- Any edge not leaving GRANTx: both acks <= 0.
- Addresses are not range-checked or realigned; word selection is the memory's job.

## Timing
- Reset (sampled low at an edge), all values apply from the next cycle:
  - state = IDLE, last_grant = 1 (master 0 wins the first tie).
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0.
  - cmd_* = 0; both memory enables 0.
- Latency: req sampled in cycle T (IDLE) → memory access in T+1 → ack and rdata in T+2.
- Write commit: the memory writes at the rising edge that ends cycle T+1.
- Requester rule: drop req or present a new command at the edge after seeing ack.
  - A req still high in the ack cycle is ignored (masked).
- Peak throughput: one access per 2 cycles across both masters, one per 3 cycles for a single master.
- Simultaneous requests in round-robin mode: grants alternate 0,1,0,1…; neither master starves.
  - Worst-case wait: one foreign access, 2 cycles.
- Reset in a GRANT cycle:
  - The enables are gated by reset_n, so no write or read occurs.
  - No ack is issued; the FSM returns to IDLE.
- A req dropped before its ack is a protocol violation; the latched command still completes.

## Test plan
- Single write, then read: m0 writes 0xBEEF to addr 0x010, then reads it.
  - mem_write_en is high for exactly one cycle, 1 cycle after req.
  - Write ack arrives 2 cycles after req; read ack arrives with m0_rdata = 0xBEEF.
- Simultaneous reads after reset, round-robin: m0 reads 0x000, m1 reads 0x002.
  - Expect the GRANT0 ack first, then the GRANT1 ack 2 cycles later.
  - Expect each rdata to match its preloaded word.
- Both masters hold req continuously (new command after each ack) for 8 accesses.
  - Grants strictly alternate.
  - No master has two consecutive grants while the other is eligible.
- FIXED_PRIO=1, both requesting: m0 is granted every time it is eligible.
  - m1 is granted only in IDLE cycles where m0 is masked or idle.
- Reset pulse in a GRANT cycle of an m1 write of 0x1234 to 0x020.
  - The memory word stays unchanged, no ack is issued, all outputs are at reset values.
- Masking: m0 keeps req high one cycle into its ack.
  - No duplicate grant occurs; the next grant goes to m1 if it is requesting, otherwise the FSM stays in IDLE.
